// File: rtl/sine_pkg.sv
// Shared types and default widths for the sine ROM address generator.
//   state_t : controller state encoding (IDLE / RUN / FIN)
//   ADDR_W  : default ROM address width
//   ACC_W   : default phase accumulator width
//   CNT_W   : default burst length counter width
package sine_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int ADDR_W = 8;
   localparam int ACC_W  = 16;
   localparam int CNT_W  = 16;

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator register with clear / load / add / hold, plus extraction
// of the top ADDRESS_WIDTH bits used as the ROM phase address.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : acc <= 0 (highest priority)
//   load       : acc <= load_val
//   add        : acc <= acc + incr (wraps modulo 2^ACC_WIDTH)
//   acc        : current accumulator value
//   phase      : acc[ACC_WIDTH-1 -: ADDRESS_WIDTH]
module sine_phase_acc
   import sine_pkg::*;
#(
   parameter int ACC_WIDTH     = ACC_W,
   parameter int ADDRESS_WIDTH = ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     load,
   input  logic [ACC_WIDTH-1:0]     load_val,
   input  logic                     add,
   input  logic [ACC_WIDTH-1:0]     incr,
   output logic [ACC_WIDTH-1:0]     acc,
   output logic [ADDRESS_WIDTH-1:0] phase
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (load) begin
         acc <= load_val;
      end else if (add) begin
         acc <= acc + incr;
      end
   end

   assign phase = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];

endmodule

// File: rtl/sine_phase_gen.sv
// Address generator for the dual-port sine ROM. A phase accumulator advances
// by a tuning word on each enabled cycle; port 1 gets the top address bits,
// port 2 the same address plus a phase offset. Runs a fixed-length burst or
// continuously (burst_len == 0) until stopped.
//
// Optional build macro SINE_PHASE_LOAD_EN adds phase_load / phase_init to
// preset the accumulator at start and to reload it mid-run.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a run (IDLE only)
//   stop              : abort a run (RUN only, beats en)
//   en                : advance enable, low pauses the run
//   incr              : tuning word, latched at start
//   offset            : port-2 phase offset, latched at start
//   burst_len         : sample count, 0 = continuous, latched at start
//   phase_load        : (optional) load phase_init instead of accumulating
//   phase_init        : (optional) accumulator preset value
//   addr1, addr2      : ROM port addresses, hold when addr_valid is low
//   addr_valid        : addr1/addr2 carry a new sample
//   rom_valid         : addr_valid delayed one cycle, aligned with ROM data
//   busy              : state is not IDLE
//   done              : one-cycle pulse after the last burst sample
//
// state | meaning
// IDLE  | waiting for start, accumulator parked
// RUN   | issuing samples on enabled cycles
// FIN   | burst complete, pulse done
module sine_phase_gen
   import sine_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDR_W,
   parameter int ACC_WIDTH     = ACC_W,
   parameter int CNT_WIDTH     = CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     en,
   input  logic [ACC_WIDTH-1:0]     incr,
   input  logic [ADDRESS_WIDTH-1:0] offset,
   input  logic [CNT_WIDTH-1:0]     burst_len,
`ifdef SINE_PHASE_LOAD_EN
   input  logic                     phase_load,
   input  logic [ACC_WIDTH-1:0]     phase_init,
`endif
   output logic [ADDRESS_WIDTH-1:0] addr1,
   output logic [ADDRESS_WIDTH-1:0] addr2,
   output logic                     addr_valid,
   output logic                     rom_valid,
   output logic                     busy,
   output logic                     done
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                     state;
   state_t                     state_nxt;
   logic [ACC_WIDTH-1:0]       incr_q;
   logic [ADDRESS_WIDTH-1:0]   offset_q;
   logic [CNT_WIDTH-1:0]       cnt;

   logic                       take_start;
   logic                       step;
   logic                       acc_clr;
   logic                       acc_load;
   logic                       acc_add;
   logic [ACC_WIDTH-1:0]       acc_load_val;
   logic [ACC_WIDTH-1:0]       acc;
   logic [ADDRESS_WIDTH-1:0]   phase;

   assign take_start = (state == IDLE) && start;
   assign step       = (state == RUN) && !stop && en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // cnt == 0 at the top of a run never reaches the terminal count, so a
   // continuous run only leaves RUN through stop.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (en && (cnt == CNT_ONE)) begin
               state_nxt = FIN;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      acc_clr      = 1'b0;
      acc_load     = 1'b0;
      acc_add      = 1'b0;
      acc_load_val = '0;
`ifdef SINE_PHASE_LOAD_EN
      acc_load_val = phase_init;
      acc_clr      = take_start && !phase_load;
      acc_load     = (take_start || step) && phase_load;
      acc_add      = step && !phase_load;
`else
      acc_clr      = take_start;
      acc_add      = step;
`endif
   end

   sine_phase_acc #(
      .ACC_WIDTH     (ACC_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .load     (acc_load),
      .load_val (acc_load_val),
      .add      (acc_add),
      .incr     (incr_q),
      .acc      (acc),
      .phase    (phase)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         incr_q     <= '0;
         offset_q   <= '0;
         cnt        <= '0;
         addr1      <= '0;
         addr2      <= '0;
         addr_valid <= 1'b0;
         rom_valid  <= 1'b0;
         done       <= 1'b0;
      end else begin
         rom_valid  <= addr_valid;
         addr_valid <= 1'b0;
         done       <= 1'b0;
         if (take_start) begin
            incr_q   <= incr;
            offset_q <= offset;
            cnt      <= burst_len;
         end
         if (step) begin
            addr1      <= phase;
            addr2      <= phase + offset_q;
            addr_valid <= 1'b1;
            if (cnt != '0) begin
               cnt <= cnt - CNT_ONE;
            end
         end
         if (state == FIN) begin
            done <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed self-checking bench for sine_phase_gen. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_sine_phase_gen;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        en;
   logic [15:0] incr;
   logic [7:0]  offset;
   logic [15:0] burst_len;
`ifdef SINE_PHASE_LOAD_EN
   logic        phase_load;
   logic [15:0] phase_init;
`endif
   logic [7:0]  addr1;
   logic [7:0]  addr2;
   logic        addr_valid;
   logic        rom_valid;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   sine_phase_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .en         (en),
      .incr       (incr),
      .offset     (offset),
      .burst_len  (burst_len),
`ifdef SINE_PHASE_LOAD_EN
      .phase_load (phase_load),
      .phase_init (phase_init),
`endif
      .addr1      (addr1),
      .addr2      (addr2),
      .addr_valid (addr_valid),
      .rom_valid  (rom_valid),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
      incr = '0; offset = '0; burst_len = '0;
`ifdef SINE_PHASE_LOAD_EN
      phase_load = 1'b0; phase_init = '0;
`endif
      tick(); tick();
      n_cmp++;
      if ({addr1, addr2, addr_valid, rom_valid, busy, done} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_state: got a1=%h a2=%h av=%b rv=%b busy=%b done=%b, want all 0",
                  addr1, addr2, addr_valid, rom_valid, busy, done);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_burst();
      logic [7:0] exp1 [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
      logic [7:0] exp2 [4] = '{8'h40, 8'h41, 8'h42, 8'h43};
      incr = 16'h0100; offset = 8'h40; burst_len = 16'd4; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      incr = 16'h1234; offset = 8'h11; burst_len = 16'd99;
      n_cmp++;
      if (busy !== 1'b1 || addr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL burst_start: got busy=%b av=%b, want busy=1 av=0", busy, addr_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (addr_valid !== 1'b1 || addr1 !== exp1[i] || addr2 !== exp2[i] ||
             rom_valid !== (i > 0) || done !== 1'b0) begin
            n_err++;
            $display("FAIL burst_sample%0d: got av=%b a1=%h a2=%h rv=%b done=%b, want av=1 a1=%h a2=%h rv=%b done=0",
                     i, addr_valid, addr1, addr2, rom_valid, done, exp1[i], exp2[i], (i > 0));
         end
      end
      tick();
      n_cmp++;
      if (done !== 1'b1 || addr_valid !== 1'b0 || rom_valid !== 1'b1 || busy !== 1'b0 ||
          addr1 !== 8'h03 || addr2 !== 8'h43) begin
         n_err++;
         $display("FAIL burst_done: got done=%b av=%b rv=%b busy=%b a1=%h a2=%h, want done=1 av=0 rv=1 busy=0 a1=03 a2=43",
                  done, addr_valid, rom_valid, busy, addr1, addr2);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || rom_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL burst_after: got done=%b rv=%b busy=%b, want 0 0 0", done, rom_valid, busy);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp1 [6] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
      logic [7:0] exp2 [6] = '{8'hF0, 8'h30, 8'h70, 8'hB0, 8'hF0, 8'h30};
      incr = 16'h4000; offset = 8'hF0; burst_len = 16'd6; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if (addr_valid !== 1'b1 || addr1 !== exp1[i] || addr2 !== exp2[i]) begin
            n_err++;
            $display("FAIL wrap_sample%0d: got av=%b a1=%h a2=%h, want av=1 a1=%h a2=%h",
                     i, addr_valid, addr1, addr2, exp1[i], exp2[i]);
         end
      end
      tick();
      n_cmp++;
      if (done !== 1'b1 || addr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_done: got done=%b av=%b, want done=1 av=0", done, addr_valid);
      end
      tick();
   endtask

   task automatic test_pause();
      logic       en_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] exp_a1  [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
      int         n_valid = 0;
      incr = 16'h0100; offset = 8'h00; burst_len = 16'd3; en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en = en_pat[i];
         tick();
         if (addr_valid === 1'b1) n_valid++;
         n_cmp++;
         if (addr_valid !== en_pat[i] || addr1 !== exp_a1[i] || done !== 1'b0) begin
            n_err++;
            $display("FAIL pause_step%0d: got av=%b a1=%h done=%b, want av=%b a1=%h done=0",
                     i, addr_valid, addr1, done, en_pat[i], exp_a1[i]);
         end
      end
      en = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1 || n_valid != 3) begin
         n_err++;
         $display("FAIL pause_done: got done=%b samples=%0d, want done=1 samples=3", done, n_valid);
      end
      tick();
   endtask

   task automatic test_cont_stop();
      int n_done  = 0;
      int n_valid = 0;
      incr = 16'h0100; offset = 8'h05; burst_len = 16'd0; en = 1'b1;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL start_with_stop: got busy=%b, want 1", busy);
      end
      for (int i = 0; i < 300; i++) begin
         tick();
         if (done === 1'b1) n_done++;
         if (addr_valid === 1'b1) n_valid++;
      end
      n_cmp++;
      if (addr1 !== 8'h2B || addr2 !== 8'h30 || n_valid != 300 || n_done != 0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL cont_run: got a1=%h a2=%h samples=%0d dones=%0d busy=%b, want a1=2b a2=30 samples=300 dones=0 busy=1",
                  addr1, addr2, n_valid, n_done, busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (addr1 !== 8'h2C || addr_valid !== 1'b1) begin
         n_err++;
         $display("FAIL start_while_busy: got a1=%h av=%b, want a1=2c av=1", addr1, addr_valid);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_cmp++;
      if (addr_valid !== 1'b0 || busy !== 1'b0 || rom_valid !== 1'b1 || done !== 1'b0 || addr1 !== 8'h2C) begin
         n_err++;
         $display("FAIL stop: got av=%b busy=%b rv=%b done=%b a1=%h, want av=0 busy=0 rv=1 done=0 a1=2c",
                  addr_valid, busy, rom_valid, done, addr1);
      end
      tick();
      n_cmp++;
      if (rom_valid !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL after_stop: got rv=%b done=%b av=%b, want 0 0 0", rom_valid, done, addr_valid);
      end
      en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n_done = 0;
      incr = 16'h0100; offset = 8'h10; burst_len = 16'd10; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({addr1, addr2, addr_valid, rom_valid, busy, done} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_mid: got a1=%h a2=%h av=%b rv=%b busy=%b done=%b, want all 0",
                  addr1, addr2, addr_valid, rom_valid, busy, done);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1 || addr_valid === 1'b1) n_done++;
      end
      n_cmp++;
      if (n_done != 0) begin
         n_err++;
         $display("FAIL reset_mid_after: got %0d active cycles after release, want 0", n_done);
      end
      en = 1'b0;
   endtask

`ifdef SINE_PHASE_LOAD_EN
   task automatic test_phase_load();
      incr = 16'h0100; offset = 8'h00; burst_len = 16'd0; en = 1'b1; start = 1'b1;
      phase_load = 1'b1; phase_init = 16'h8000;
      tick();
      start = 1'b0; phase_load = 1'b0;
      tick();
      n_cmp++;
      if (addr1 !== 8'h80 || addr_valid !== 1'b1) begin
         n_err++;
         $display("FAIL load_start: got a1=%h av=%b, want a1=80 av=1", addr1, addr_valid);
      end
      tick();
      phase_load = 1'b1; phase_init = 16'h1000;
      tick();
      phase_load = 1'b0;
      n_cmp++;
      if (addr1 !== 8'h82) begin
         n_err++;
         $display("FAIL load_mid_same: got a1=%h, want 82", addr1);
      end
      tick();
      n_cmp++;
      if (addr1 !== 8'h10) begin
         n_err++;
         $display("FAIL load_mid_next: got a1=%h, want 10", addr1);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0; en = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_burst();
      test_wrap();
      test_pause();
      test_cont_stop();
      test_reset_mid();
`ifdef SINE_PHASE_LOAD_EN
      test_phase_load();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sine_phase_gen.md
Name: sine_phase_gen

Overview:
- Upstream address generator for the dual-port sine lookup ROM.
- A phase accumulator advances by a programmable tuning word each enabled cycle. Its top ADDRESS_WIDTH bits drive ROM port 1; port 2 gets the same address plus a phase offset.
- Runs either a fixed-length burst or continuously.
- Provides a valid flag aligned to the ROM's one-cycle read latency.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; also the width of offset, addr1 and addr2.
- ACC_WIDTH, 16, phase accumulator width; must be >= ADDRESS_WIDTH.
- CNT_WIDTH, 16, width of the burst length counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort a run; sampled only in RUN.
- en  in  1  advance enable; low pauses the run.
- incr  in  ACC_WIDTH  tuning word; latched at start.
- offset  in  ADDRESS_WIDTH  port-2 phase offset; latched at start.
- burst_len  in  CNT_WIDTH  number of samples; 0 means continuous; latched at start.
- addr1  out  ADDRESS_WIDTH  ROM port-1 address.
- addr2  out  ADDRESS_WIDTH  ROM port-2 address.
- addr_valid  out  1  addr1/addr2 carry a new sample this cycle.
- rom_valid  out  1  addr_valid delayed by one cycle; aligned with ROM data1/data2.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, acc=0.
  - addr1=addr2=0, addr_valid=rom_valid=done=0.
  - incr_q, offset_q and cnt cleared.
  - Reset mid-run abandons the run immediately; no done pulse.
- All outputs are registered; busy is decoded from state.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - addr_valid<=0.
  - On start=1: incr_q<=incr, offset_q<=offset, cnt<=burst_len, acc<=0, next state RUN.
- RUN, priority stop > en:
  - stop=1: addr_valid<=0, next IDLE, no done. Any sample pending that cycle is not issued.
  - en=0: addr_valid<=0; acc and cnt hold.
  - en=1:
    - addr1<=acc[ACC_WIDTH-1 -: ADDRESS_WIDTH].
    - addr2<=that value + offset_q, modulo 2^ADDRESS_WIDTH.
    - addr_valid<=1; acc<=acc+incr_q, modulo 2^ACC_WIDTH (natural wrap).
    - If cnt!=0: cnt<=cnt-1; if cnt==1, next FIN.
    - If cnt==0 at start of run (continuous mode): cnt never decrements; run ends only by stop.
- FIN: addr_valid<=0, done<=1 for exactly one cycle, next IDLE.
- done is 0 in every other cycle.
- Latency:
  - start sampled at edge N → first addr_valid (addr1=0) after edge N+1, provided en=1 at N+1.
  - Matching rom_valid after edge N+2.
- rom_valid<=addr_valid every cycle, including after stop. The last in-flight ROM read is still flagged valid.
- addr1/addr2 hold their last values whenever addr_valid=0.
- start while busy is ignored. Changes to incr, offset and burst_len during a run have no effect.
- start and stop asserted together in IDLE: start is taken, stop ignored.
- Burst of N samples issues exactly N addr_valid pulses regardless of en gaps; done follows the last sample by one cycle.

Optional Feature:
- Macro: SINE_PHASE_LOAD_EN.
- When defined:
  - Adds ports phase_load (in, 1) and phase_init (in, ACC_WIDTH).
  - At start, acc<=phase_init if phase_load=1, else 0.
  - In RUN, phase_load=1 with en=1 replaces the accumulate step: acc<=phase_init. Addresses issued that cycle still use the old acc; cnt decrements normally.
  - stop still has priority.
- When undefined: ports absent; acc always starts at 0.

Decomposition:
- Shared package sine_pkg:
  - state enum typedef (IDLE/RUN/FIN).
  - default width constants ADDR_W=8, ACC_W=16, CNT_W=16.
- One natural sub-module, sine_phase_acc: accumulator register with clear/load/add/hold and top-bit extraction.
- FSM, counter and address/valid pipeline stay in sine_phase_gen.

Test Plan:
- Reset mid-burst: assert rst_n=0 during RUN → all outputs 0 asynchronously; busy=0; no done after release.
- Burst:
  - incr=0x0100, offset=0x40, burst_len=4, en=1 → addr1 = 0x00,0x01,0x02,0x03 and addr2 = 0x40,0x41,0x42,0x43 on 4 consecutive cycles.
  - done pulses once, one cycle after the last sample.
  - rom_valid lags addr_valid by exactly 1 cycle.
- Wrap: incr=0x4000, offset=0xF0, burst_len=6 → addr1 = 0x00,0x40,0x80,0xC0,0x00,0x40; addr2 = 0xF0,0x30,0x70,0xB0,0xF0,0x30.
- Pause:
  - burst_len=3, en toggled 1,0,0,1,1 → exactly 3 valid samples with consecutive phases; no skipped phase.
  - done after the third sample.
- Continuous + stop:
  - burst_len=0, run 300 cycles, then stop=1 → addr_valid=0 next cycle; busy=0; done never asserts; one trailing rom_valid.
  - start asserted while busy has no effect (acc not cleared).
- SINE_PHASE_LOAD_EN:
  - phase_load=1, phase_init=0x8000 at start, incr=0x0100 → first addr1=0x80.
  - Mid-run load of 0x1000 → next-but-one addr1=0x10.
